vend_sequencer: RTL
===================

// Module: vend_sequencer
// PURPOSE
//  Transaction controller around the coin accumulator: counts coin strobes, adds
//  coin values into a running total, compares the total with a latched price and
//  issues a one-cycle dispense/change result. It also handles cancel, inactivity
//  timeout and adder overflow. It sits between the coin-sensor front end and the
//  dispenser/change-return logic.
// PARAMETERS
//  W        8     width of value/price/tot/change (unsigned)
//  TIMEOUT  1000  idle cycles in WAIT_LOW (with tot!=0) before auto-refund; >=2
//  TW       10    timer width; 2**TW >= TIMEOUT
// PORTS
//  clk          in   1  single clock; all state updates on posedge clk
//  rst          in   1  synchronous, active-high reset
//  x            in   1  coin sensor; low while a coin is present, high otherwise
//  value        in   W  value of the coin present; valid while x==0
//  price        in   W  item price; latched in IDLE only
//  cancel       in   1  level; refund request, honoured only in WAIT_LOW
//  tot          out  W  running total inserted in this transaction
//  change       out  W  change/refund amount; holds until next result
//  change_valid out  1  1-cycle pulse when change is updated
//  dispense     out  1  1-cycle pulse: item paid for
//  err_ovf      out  1  1-cycle pulse: coin rejected, tot+value > 2**W-1
//  busy         out  1  1 in ADD, WAIT_HIGH, CHECK, VEND, REFUND
// BEHAVIOUR
//  Reset (rst=1 at posedge, any state): state=IDLE, tot=0, change=0, price_q=0,
//   timer=0, change_valid=dispense=err_ovf=0. This aborts any transaction with no
//   refund pulse.
//  All outputs are registered. The pulses are high for exactly one cycle after the
//   transition that creates them.
//  IDLE: tot<=0, price_q<=price, timer<=0; next state is WAIT_LOW (always 1 cycle).
//  WAIT_LOW, evaluated in priority order:
//   1) cancel==1 && tot!=0 -> REFUND
//   2) tot!=0 && timer==TIMEOUT-1 -> REFUND
//   3) x==0 -> ADD
//   4) otherwise stay; timer++ if tot!=0, else timer holds at 0.
//   cancel with tot==0 is ignored.
//  ADD: sum = {1'b0,tot}+value (W+1 bits).
//   sum[W]==0: tot<=sum[W-1:0].
//   sum[W]==1: tot unchanged, err_ovf pulse.
//   Either way: timer<=0 -> WAIT_HIGH.
//   value is sampled exactly once per coin, in this cycle.
//  WAIT_HIGH: stay until x==1, then -> CHECK. cancel and timer are ignored.
//  CHECK: price_q!=0 && tot>=price_q -> VEND; else -> WAIT_LOW.
//  VEND: dispense<=1, change<=tot-price_q, change_valid<=1 -> IDLE.
//  REFUND: change<=tot, change_valid<=1 -> IDLE.
//  Minimum coin-to-result latency: x low sampled in WAIT_LOW, then ADD, then
//   WAIT_HIGH (x high), CHECK, VEND. The dispense pulse is visible 4 cycles after
//   the x=0 sample.
//  Changes to price mid-transaction have no effect until the next IDLE.
//  tot returns to 0 in IDLE, so it reads 0 in the cycle after a VEND or REFUND
//   result.
// TESTING
//  T1 price=150, coins 100 then 50 -> after 2nd CHECK: dispense=1,
//     change=0, change_valid=1, then tot=0.
//  T2 price=150, coins 100 then 100 -> dispense=1, change=50.
//  T3 price=150, coin 100, then cancel=1 for 1 cycle in WAIT_LOW -> REFUND:
//     change=100, dispense stays 0.
//  T4 TIMEOUT=8, coin 25, no further activity -> exactly 8 WAIT_LOW cycles,
//     then change=25 and change_valid pulses.
//  T5 price=255, coins 200 then 100 -> err_ovf pulses, tot stays 200, no
//     dispense. A following coin 55 -> dispense, change=0.
//  T6 rst=1 during WAIT_HIGH with tot=100 -> next cycle all outputs 0,
//     state IDLE, no change_valid. Also price=0 with coin 10 -> never dispenses.

Source files
------------

// File: rtl/vend_sequencer.sv
// Coin-accumulator transaction controller: sums coins, compares the total against a
// price latched at transaction start, and issues one-cycle dispense/change results.
//
// state      | meaning
// IDLE       | clear total, latch price, arm timer
// WAIT_LOW   | wait for a coin, cancel or inactivity timeout
// ADD        | add the coin value once, flag overflow
// WAIT_HIGH  | wait for the coin to leave the sensor
// CHECK      | compare total with latched price
// VEND       | dispense pulse, change = total - price
// REFUND     | change = total (cancel or timeout)
module vend_sequencer #(
  parameter int W       = 8,
  parameter int TIMEOUT = 1000,
  parameter int TW      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         x,
  input  logic [W-1:0] value,
  input  logic [W-1:0] price,
  input  logic         cancel,
  output logic [W-1:0] tot,
  output logic [W-1:0] change,
  output logic         change_valid,
  output logic         dispense,
  output logic         err_ovf,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOW, S_ADD, S_WAIT_HIGH, S_CHECK, S_VEND, S_REFUND
  } state_t;

  // Timer counts down the remaining idle cycles; zero means the last allowed one.
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

  state_t         state, state_next;
  logic [W-1:0]   price_q, price_q_next;
  logic [W-1:0]   tot_next, change_next;
  logic [TW-1:0]  timer, timer_next;
  logic           change_valid_next, dispense_next, err_ovf_next, busy_next;
  logic [W:0]     sum;
  logic           tot_nz;

  always_comb begin
    state_next        = state;
    price_q_next      = price_q;
    tot_next          = tot;
    change_next       = change;
    timer_next        = timer;
    change_valid_next = 1'b0;
    dispense_next     = 1'b0;
    err_ovf_next      = 1'b0;
    sum               = {1'b0, tot} + {1'b0, value};
    tot_nz            = (tot != '0);

    case (state)
      S_IDLE: begin
        tot_next     = '0;
        price_q_next = price;
        timer_next   = TIMER_LOAD;
        state_next   = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (cancel && tot_nz) begin
          state_next = S_REFUND;
        end else if (tot_nz && (timer == '0)) begin
          state_next = S_REFUND;
        end else if (!x) begin
          state_next = S_ADD;
        end else if (tot_nz) begin
          timer_next = timer - TW'(1);
        end
      end
      S_ADD: begin
        if (sum[W]) begin
          err_ovf_next = 1'b1;
        end else begin
          tot_next = sum[W-1:0];
        end
        timer_next = TIMER_LOAD;
        state_next = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (x) state_next = S_CHECK;
      end
      S_CHECK: begin
        if ((price_q != '0) && (tot >= price_q)) state_next = S_VEND;
        else                                     state_next = S_WAIT_LOW;
      end
      S_VEND: begin
        dispense_next     = 1'b1;
        change_next       = tot - price_q;
        change_valid_next = 1'b1;
        state_next        = S_IDLE;
      end
      S_REFUND: begin
        change_next       = tot;
        change_valid_next = 1'b1;
        state_next        = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    busy_next = (state_next == S_ADD) || (state_next == S_WAIT_HIGH) ||
                (state_next == S_CHECK) || (state_next == S_VEND) ||
                (state_next == S_REFUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      price_q      <= '0;
      tot          <= '0;
      change       <= '0;
      timer        <= '0;
      change_valid <= 1'b0;
      dispense     <= 1'b0;
      err_ovf      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      price_q      <= price_q_next;
      tot          <= tot_next;
      change       <= change_next;
      timer        <= timer_next;
      change_valid <= change_valid_next;
      dispense     <= dispense_next;
      err_ovf      <= err_ovf_next;
      busy         <= busy_next;
    end
  end

endmodule
